// File: rtl/mdp_pkg.sv
// Shared types and constants for the market-data feed arbiter.
package mdp_pkg;

  // Default maximum forwarded packet length in bytes, headers included.
  localparam int MAX_LEN_DEFAULT = 1518;

  // Smallest byte counter width used regardless of MAX_LEN.
  localparam int MIN_CNT_W = 11;

  // Arbiter control states.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PASS,
    ST_FLUSH
  } arb_state_t;

  // Identifies one of the two input feeds.
  typedef logic feed_id_t;

  localparam feed_id_t FEED_A = 1'b0;
  localparam feed_id_t FEED_B = 1'b1;

  // Byte counter width: wide enough to reach max_len, never below MIN_CNT_W.
  function automatic int cnt_width(input int max_len);
    int w;
    w = $clog2(max_len + 1);
    if (w < MIN_CNT_W) begin
      w = MIN_CNT_W;
    end
    return w;
  endfunction

endpackage

// File: rtl/feed_rr_arb.sv
// Two-way packet-level round-robin pick between feed A and feed B.
// The pointer remembers the feed granted last; on a tie the other feed wins.
module feed_rr_arb
  import mdp_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       take,
  output logic       gnt_valid,
  output feed_id_t   gnt_id
);

  feed_id_t last_id;

  // Pick a winner: the only requester, or on a tie the feed not granted last.
  always_comb begin
    gnt_valid = |req;
    gnt_id    = FEED_A;
    if (req == 2'b11) begin
      gnt_id = (last_id == FEED_A) ? FEED_B : FEED_A;
    end else if (req[1]) begin
      gnt_id = FEED_B;
    end
  end

  // Remember the granted feed; reset value makes A the winner of the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_id <= FEED_B;
    end else if (take && gnt_valid) begin
      last_id <= gnt_id;
    end
  end

endmodule

// File: rtl/feed_arbiter.sv
// Merges two MAC byte streams into one stream for the UDP parser, one whole
// packet at a time, truncating packets that exceed MAX_LEN bytes.
module feed_arbiter
  import mdp_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  s0_axis_tdata,
  input  logic        s0_axis_tvalid,
  input  logic        s0_axis_tlast,
  output logic        s0_axis_tready,
  input  logic [7:0]  s1_axis_tdata,
  input  logic        s1_axis_tvalid,
  input  logic        s1_axis_tlast,
  output logic        s1_axis_tready,
  input  logic [1:0]  feed_en,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  output feed_id_t    grant_id,
  output logic        busy,
  output logic [31:0] pkt_cnt0,
  output logic [31:0] pkt_cnt1,
  output logic [15:0] trunc_cnt
);

  localparam int CNT_W = cnt_width(MAX_LEN);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX_LEN - 1);

  arb_state_t       state;
  arb_state_t       state_nxt;
  feed_id_t         grant_q;
  logic [CNT_W-1:0] byte_cnt;

  logic [1:0] req;
  logic       gnt_valid;
  feed_id_t   gnt_id;
  logic       arb_take;

  logic [7:0] sel_data;
  logic       sel_valid;
  logic       sel_last;

  logic hs;
  logic at_limit;
  logic pass_hs;
  logic done_hit;
  logic trunc_hit;

  assign req      = {s1_axis_tvalid & feed_en[1], s0_axis_tvalid & feed_en[0]};
  assign arb_take = (state == ST_IDLE);

  feed_rr_arb u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .take      (arb_take),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  // Route the granted feed's stream onto the internal selected-feed signals.
  always_comb begin
    sel_data  = s0_axis_tdata;
    sel_valid = s0_axis_tvalid;
    sel_last  = s0_axis_tlast;
    if (grant_q == FEED_B) begin
      sel_data  = s1_axis_tdata;
      sel_valid = s1_axis_tvalid;
      sel_last  = s1_axis_tlast;
    end
  end

  // Only the granted feed is accepted, and only while a packet is in flight.
  always_comb begin
    busy           = 1'b0;
    s0_axis_tready = 1'b0;
    s1_axis_tready = 1'b0;
    if (state != ST_IDLE) begin
      busy = 1'b1;
      if (grant_q == FEED_A) begin
        s0_axis_tready = 1'b1;
      end else begin
        s1_axis_tready = 1'b1;
      end
    end
  end

  assign hs        = sel_valid && (state != ST_IDLE);
  assign at_limit  = (byte_cnt == LAST_IDX);
  assign pass_hs   = hs && (state == ST_PASS);
  assign done_hit  = pass_hs && sel_last;
  assign trunc_hit = pass_hs && !sel_last && at_limit;

  // Next-state logic: arbitrate in IDLE, forward in PASS, discard the tail in FLUSH.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (gnt_valid) begin
          state_nxt = ST_PASS;
        end
      end
      ST_PASS: begin
        if (done_hit) begin
          state_nxt = ST_IDLE;
        end else if (trunc_hit) begin
          state_nxt = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (hs && sel_last) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Latch the feed that wins arbitration; it stays visible after the packet ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q <= FEED_A;
    end else if (arb_take && gnt_valid) begin
      grant_q <= gnt_id;
    end
  end

  assign grant_id = grant_q;

  // Count forwarded bytes of the current packet; cleared when a packet is granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt <= '0;
    end else if (arb_take && gnt_valid) begin
      byte_cnt <= '0;
    end else if (pass_hs) begin
      byte_cnt <= byte_cnt + CNT_W'(1);
    end
  end

  // Registered output stream; tlast is forced on the byte that hits MAX_LEN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end else begin
      m_axis_tvalid <= pass_hs;
      m_axis_tlast  <= pass_hs && (sel_last || at_limit);
      if (pass_hs) begin
        m_axis_tdata <= sel_data;
      end
    end
  end

  // Per-feed completed packet counters and the truncation counter; all wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt0  <= '0;
      pkt_cnt1  <= '0;
      trunc_cnt <= '0;
    end else begin
      if (done_hit && (grant_q == FEED_A)) begin
        pkt_cnt0 <= pkt_cnt0 + 32'd1;
      end
      if (done_hit && (grant_q == FEED_B)) begin
        pkt_cnt1 <= pkt_cnt1 + 32'd1;
      end
      if (trunc_hit) begin
        trunc_cnt <= trunc_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_feed_arbiter.sv
// Randomized scoreboard bench for feed_arbiter with a packet-level reference model.
module tb_feed_arbiter;
  import mdp_pkg::*;

  localparam int MAXLEN     = 64;
  localparam int WAIT_LIMIT = 2000;

  logic        clk;
  logic        rst_n;
  logic [7:0]  s0_axis_tdata;
  logic        s0_axis_tvalid;
  logic        s0_axis_tlast;
  logic        s0_axis_tready;
  logic [7:0]  s1_axis_tdata;
  logic        s1_axis_tvalid;
  logic        s1_axis_tlast;
  logic        s1_axis_tready;
  logic [1:0]  feed_en;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  feed_id_t    grant_id;
  logic        busy;
  logic [31:0] pkt_cnt0;
  logic [31:0] pkt_cnt1;
  logic [15:0] trunc_cnt;

  feed_arbiter #(.MAX_LEN(MAXLEN)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .s0_axis_tdata  (s0_axis_tdata),
    .s0_axis_tvalid (s0_axis_tvalid),
    .s0_axis_tlast  (s0_axis_tlast),
    .s0_axis_tready (s0_axis_tready),
    .s1_axis_tdata  (s1_axis_tdata),
    .s1_axis_tvalid (s1_axis_tvalid),
    .s1_axis_tlast  (s1_axis_tlast),
    .s1_axis_tready (s1_axis_tready),
    .feed_en        (feed_en),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tlast   (m_axis_tlast),
    .grant_id       (grant_id),
    .busy           (busy),
    .pkt_cnt0       (pkt_cnt0),
    .pkt_cnt1       (pkt_cnt1),
    .trunc_cnt      (trunc_cnt)
  );

  typedef struct {
    int          feed;
    int          len;
    int          start;
    logic [31:0] seed;
  } pkt_t;

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic       feed;
  } beat_t;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  beat_t       beat_q[$];
  int          due_q[$];
  pkt_t        pa[$];
  pkt_t        pb[$];
  int          last_grant;
  logic [31:0] exp_cnt0;
  logic [31:0] exp_cnt1;
  logic [31:0] exp_trunc;
  bit          mon_en = 0;
  bit          watch_a = 0;
  bit          a_ready_seen = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [7:0] pkt_byte(input pkt_t p, input int idx);
    logic [31:0] v;
    v = p.seed + 32'(37 * (idx + p.start));
    return v[7:0] ^ v[15:8];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // Reference model: a packet contributes min(len, MAXLEN) beats, last one flagged.
  function automatic void model_packet(input pkt_t p);
    int    n;
    beat_t b;
    n = (p.len > MAXLEN) ? MAXLEN : p.len;
    for (int i = 0; i < n; i++) begin
      b.data = pkt_byte(p, i);
      b.last = (i == n - 1);
      b.feed = 1'(p.feed);
      beat_q.push_back(b);
    end
    if (p.len > MAXLEN) exp_trunc = exp_trunc + 32'd1;
    else if (p.feed == 0) exp_cnt0 = exp_cnt0 + 32'd1;
    else exp_cnt1 = exp_cnt1 + 32'd1;
    last_grant = p.feed;
  endfunction

  // Packet order: with both feeds always offering a packet they alternate.
  function automatic void model_order(input logic [1:0] en);
    int ia;
    int ib;
    bit ca;
    bit cb;
    bit pick_b;
    ia = 0;
    ib = 0;
    ca = en[0] && (ia < pa.size());
    cb = en[1] && (ib < pb.size());
    while (ca || cb) begin
      if (ca && cb) pick_b = (last_grant == 0);
      else pick_b = cb;
      if (pick_b) begin
        model_packet(pb[ib]);
        ib++;
      end else begin
        model_packet(pa[ia]);
        ia++;
      end
      ca = en[0] && (ia < pa.size());
      cb = en[1] && (ib < pb.size());
    end
  endfunction

  function automatic void model_reset();
    last_grant = 1;
    exp_cnt0   = 32'd0;
    exp_cnt1   = 32'd0;
    exp_trunc  = 32'd0;
    beat_q.delete();
    due_q.delete();
  endfunction

  task automatic drive(input int feed, input logic v, input logic [7:0] d, input logic l);
    if (feed == 0) begin
      s0_axis_tvalid = v;
      s0_axis_tdata  = d;
      s0_axis_tlast  = l;
    end else begin
      s1_axis_tvalid = v;
      s1_axis_tdata  = d;
      s1_axis_tlast  = l;
    end
  endtask

  function automatic logic feed_ready(input int feed);
    return (feed == 0) ? s0_axis_tready : s1_axis_tready;
  endfunction

  // Drives nbytes of a packet; records the cycle each forwarded byte must appear.
  task automatic send_pkt(input pkt_t p, input int gap_pct, input int nbytes);
    int waited;
    for (int i = 0; i < nbytes; i++) begin
      if (i > 0 && $urandom_range(99) < gap_pct) begin
        drive(p.feed, 1'b0, 8'h00, 1'b0);
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      drive(p.feed, 1'b1, pkt_byte(p, i), (i == p.len - 1));
      waited = 0;
      do begin
        @(negedge clk);
        waited++;
      end while (!feed_ready(p.feed) && waited < WAIT_LIMIT);
      if (!feed_ready(p.feed)) begin
        checkOutput("tready_timeout", 32'd0, 32'd1);
        drive(p.feed, 1'b0, 8'h00, 1'b0);
        return;
      end
      if (i < MAXLEN) due_q.push_back(cyc + 1);
      @(posedge clk);
      #1;
    end
    drive(p.feed, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic add_pkt(input int feed, input int len);
    pkt_t p;
    p.feed  = feed;
    p.len   = len;
    p.start = 0;
    p.seed  = $urandom;
    if (feed == 0) pa.push_back(p);
    else pb.push_back(p);
  endtask

  task automatic drain_check();
    repeat (4) @(posedge clk);
    #1;
    checkOutput("beats_outstanding", 32'(beat_q.size()), 32'd0);
    checkOutput("due_outstanding", 32'(due_q.size()), 32'd0);
    checkOutput("busy_after", 32'(busy), 32'd0);
    checkOutput("pkt_cnt0", pkt_cnt0, exp_cnt0);
    checkOutput("pkt_cnt1", pkt_cnt1, exp_cnt1);
    checkOutput("trunc_cnt", 32'(trunc_cnt), exp_trunc);
  endtask

  task automatic applyStimulus(input logic [1:0] en, input int gap_pct);
    feed_en = en;
    model_order(en);
    fork
      begin
        if (en[0]) foreach (pa[i]) send_pkt(pa[i], gap_pct, pa[i].len);
      end
      begin
        if (en[1]) foreach (pb[i]) send_pkt(pb[i], gap_pct, pb[i].len);
      end
    join
    pa.delete();
    pb.delete();
    drain_check();
  endtask

  task automatic check_reset_outputs();
    checkOutput("rst_s0_tready", 32'(s0_axis_tready), 32'd0);
    checkOutput("rst_s1_tready", 32'(s1_axis_tready), 32'd0);
    checkOutput("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
    checkOutput("rst_m_tdata", 32'(m_axis_tdata), 32'd0);
    checkOutput("rst_m_tlast", 32'(m_axis_tlast), 32'd0);
    checkOutput("rst_grant_id", 32'(grant_id), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_pkt_cnt0", pkt_cnt0, 32'd0);
    checkOutput("rst_pkt_cnt1", pkt_cnt1, 32'd0);
    checkOutput("rst_trunc_cnt", 32'(trunc_cnt), 32'd0);
  endtask

  task automatic applyReset();
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    check_reset_outputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a beat.
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      bit    exp_v;
      beat_t b;
      exp_v = 1'b0;
      while (due_q.size() > 0 && due_q[0] < cyc) begin
        void'(due_q.pop_front());
        checkOutput("beat_missing", 32'd0, 32'd1);
      end
      if (due_q.size() > 0 && due_q[0] == cyc) begin
        void'(due_q.pop_front());
        exp_v = 1'b1;
      end
      if (exp_v || m_axis_tvalid) checkOutput("m_tvalid_timing", 32'(m_axis_tvalid), 32'(exp_v));
      if (m_axis_tvalid) begin
        if (beat_q.size() == 0) begin
          checkOutput("unexpected_beat", 32'd1, 32'd0);
        end else begin
          b = beat_q.pop_front();
          checkOutput("m_tdata", 32'(m_axis_tdata), 32'(b.data));
          checkOutput("m_tlast", 32'(m_axis_tlast), 32'(b.last));
          checkOutput("grant_id", 32'(grant_id), 32'(b.feed));
        end
      end else if (m_axis_tlast) begin
        checkOutput("tlast_without_valid", 32'd1, 32'd0);
      end
      if (watch_a && s0_axis_tready) a_ready_seen = 1'b1;
    end
  end

  initial begin
    pkt_t p;
    pkt_t p2;
    beat_t b;
    rst_n   = 1'b0;
    feed_en = 2'b00;
    drive(0, 1'b0, 8'h00, 1'b0);
    drive(1, 1'b0, 8'h00, 1'b0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    applyReset();
    mon_en = 1'b1;

    $display("[TB] single 50-byte packet on A");
    add_pkt(0, 50);
    applyStimulus(2'b11, 0);

    $display("[TB] three packets on each feed from reset");
    applyReset();
    for (int i = 0; i < 3; i++) begin
      add_pkt(0, $urandom_range(1, 40));
      add_pkt(1, $urandom_range(1, 40));
    end
    applyStimulus(2'b11, 0);

    $display("[TB] 100-byte packet truncated at 64");
    applyReset();
    add_pkt(0, 100);
    applyStimulus(2'b01, 20);

    $display("[TB] length boundaries 64/65/63");
    add_pkt(0, 64);
    add_pkt(0, 65);
    add_pkt(0, 63);
    applyStimulus(2'b01, 0);

    $display("[TB] feed A disabled while valid");
    drive(0, 1'b1, 8'hA5, 1'b0);
    a_ready_seen = 1'b0;
    watch_a = 1'b1;
    for (int i = 0; i < 3; i++) add_pkt(1, $urandom_range(1, 70));
    applyStimulus(2'b10, 20);
    watch_a = 1'b0;
    checkOutput("s0_tready_disabled", 32'(a_ready_seen), 32'd0);
    drive(0, 1'b0, 8'h00, 1'b0);

    $display("[TB] random contention with gaps");
    for (int i = 0; i < 6; i++) begin
      add_pkt(0, $urandom_range(1, 90));
      add_pkt(1, $urandom_range(1, 90));
    end
    applyStimulus(2'b11, 30);

    $display("[TB] reset in the middle of a packet");
    feed_en = 2'b11;
    p.feed  = 0;
    p.len   = 50;
    p.start = 0;
    p.seed  = $urandom;
    for (int i = 0; i < 19; i++) begin
      b.data = pkt_byte(p, i);
      b.last = 1'b0;
      b.feed = 1'b0;
      beat_q.push_back(b);
    end
    send_pkt(p, 0, 19);
    drive(0, 1'b1, pkt_byte(p, 19), 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("beats_before_reset", 32'(beat_q.size()), 32'd0);
    check_reset_outputs();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    p2       = p;
    p2.len   = 31;
    p2.start = 19;
    model_packet(p2);
    send_pkt(p2, 0, 31);
    drain_check();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
